fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline latch, BOOT/RUN/HOLD
// control FSM and saturating stall/flush event counters.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        PCWrite,
   input  logic        IF_ID_Write,
   input  logic        flush,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic [31:0] instr_mem_data,
   output logic [31:0] pc_out,
   output logic [31:0] IF_ID_Instr,
   output logic [31:0] IF_ID_PCplus4,
   output logic        IF_ID_Valid,
   output logic [1:0]  fe_state,
   output logic [15:0] stall_count,
   output logic [15:0] flush_count
);

   typedef enum logic [1:0] {
      ST_BOOT = 2'b00,
      ST_RUN  = 2'b01,
      ST_HOLD = 2'b10,
      ST_BAD  = 2'b11
   } fe_state_t;

   localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;
   localparam logic [31:0] PC_INIT   = RESET_PC & WORD_MASK;

   fe_state_t   state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc4_q, pc4_d;
   logic        valid_q, valid_d;
   logic [15:0] stall_cnt_q, stall_cnt_d;
   logic [15:0] flush_cnt_q, flush_cnt_d;

   logic        stall_s;
   logic        active_s;
   logic [31:0] pc_plus4_s;
   logic [31:0] redirect_target_s;

   assign stall_s           = !PCWrite && !redirect;
   assign active_s          = (state_q != ST_BOOT);
   assign pc_plus4_s        = pc_q + 32'd4;
   assign redirect_target_s = redirect_pc & WORD_MASK;

   // Next-state logic for FSM, PC, IF/ID latch and event counters
   always_comb begin
      state_d     = ST_RUN;
      pc_d        = pc_q;
      instr_d     = instr_q;
      pc4_d       = pc4_q;
      valid_d     = valid_q;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;

      case (state_q)
         ST_BOOT: state_d = ST_RUN;
         ST_RUN:  state_d = stall_s ? ST_HOLD : ST_RUN;
         ST_HOLD: state_d = stall_s ? ST_HOLD : ST_RUN;
         default: state_d = ST_RUN;
      endcase

      if (!active_s) begin
         pc_d    = pc_q;
         instr_d = 32'h0000_0000;
         pc4_d   = 32'h0000_0000;
         valid_d = 1'b0;
      end else begin
         if (redirect) begin
            pc_d = redirect_target_s;
         end else if (!PCWrite) begin
            pc_d = pc_q;
         end else begin
            pc_d = pc_plus4_s;
         end

         // flush outranks IF_ID_Write so a squashed slot never survives a stall
         if (flush) begin
            instr_d = 32'h0000_0000;
            pc4_d   = 32'h0000_0000;
            valid_d = 1'b0;
         end else if (!IF_ID_Write) begin
            instr_d = instr_q;
            pc4_d   = pc4_q;
            valid_d = valid_q;
         end else begin
            instr_d = instr_mem_data;
            pc4_d   = pc_plus4_s;
            valid_d = 1'b1;
         end

         if (stall_s && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
         end else begin
            stall_cnt_d = stall_cnt_q;
         end

         if (flush && (flush_cnt_q != 16'hFFFF)) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
         end else begin
            flush_cnt_d = flush_cnt_q;
         end
      end
   end

   // State registers with asynchronous active-high reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_BOOT;
         pc_q        <= PC_INIT;
         instr_q     <= 32'h0000_0000;
         pc4_q       <= 32'h0000_0000;
         valid_q     <= 1'b0;
         stall_cnt_q <= 16'h0000;
         flush_cnt_q <= 16'h0000;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         instr_q     <= instr_d;
         pc4_q       <= pc4_d;
         valid_q     <= valid_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign pc_out        = pc_q;
   assign IF_ID_Instr   = instr_q;
   assign IF_ID_PCplus4 = pc4_q;
   assign IF_ID_Valid   = valid_q;
   assign fe_state      = state_q;
   assign stall_count   = stall_cnt_q;
   assign flush_count   = flush_cnt_q;

endmodule
